id_ex_hazard_reg: RTL
=====================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with built-in load-use hazard detection, directly downstream of IF/ID.
//  Latches decoded operands/control for EX and raises stall_o, which drives the PC hold and IF/ID IF_stall.
//  On a load-use hazard or flush it inserts exactly one bubble with all EX control cleared.
// PARAMETERS
//  XLEN        32  datapath width (PC, operands, immediate, instruction)
//  REG_ADDR_W  5   register index width
// PORTS
//  clk          in   1           clock, rising edge
//  rst_i        in   1           asynchronous active-high reset
//  start_i      in   1           pipeline enable; 0 = hold all state
//  start_o      out  1           registered start_i
//  flush_i      in   1           branch/redirect flush from EX; forces bubble
//  PC_i         in   XLEN        PC from IF/ID
//  instruction_i in  XLEN        instruction from IF/ID; rs1=[19:15], rs2=[24:20], rd=[11:7]
//  RS1data_i    in   XLEN        register file read port 1
//  RS2data_i    in   XLEN        register file read port 2
//  imm_i        in   XLEN        sign-extended immediate
//  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i  in 1 each  decoded control
//  ALUOp_i      in   2           ALU op class
//  PC_o, RS1data_o, RS2data_o, imm_o  out XLEN  registered copies
//  rs1_o, rs2_o, rd_o                 out REG_ADDR_W  registered register indices
//  funct_o      out  10          registered {instr[31:25], instr[14:12]}
//  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, Branch_o  out 1 each
//  ALUOp_o      out  2
//  stall_o      out  1           combinational load-use stall request
// BEHAVIOUR
//  - Reset (async, rst_i=1): every registered output = 0 immediately; stall_o therefore 0.
//  - hazard = start_i & MemRead_o & (rd_o!=0) & (rd_o==instr_i[19:15] | rd_o==instr_i[24:20]).
//    rs fields are compared for every opcode (conservative); a NOP never hazards as rd_o=0 after bubble.
//  - stall_o = hazard & ~flush_i (flush discards the stalled instruction anyway).
//  - Rising clk, rst_i=0:
//    start_i=0: all outputs hold, including start_o.
//    start_i=1: start_o<=1; then priority flush_i > hazard > normal:
//      flush_i=1 or hazard=1: bubble, all control outputs, rd/rs1/rs2, funct, data, PC, imm <= 0.
//      else: every *_o <= matching *_i; indices/funct sliced from instruction_i.
//  - Latency 1 cycle input->output. A load-use pair costs exactly one bubble: bubble clears MemRead_o,
//    so stall_o drops in the following cycle while IF/ID held the dependent instruction.
//  - Back-to-back loads with dependency on each: one bubble per dependent pair, no deadlock.
//  - flush_i and hazard in same cycle: one bubble, stall_o=0 so upstream advances.
//  - Reset mid-stall: outputs zero, stall_o released same instant.
// CONFIGURATION
//  ID_EX_BUBBLE_CNT_EN defined: adds out port bubble_cnt_o [31:0]; reset 0; +1 on each clock edge
//    where start_i=1 and a bubble is inserted due to hazard (not flush); wraps 0xFFFFFFFF->0.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: assert rst_i mid-cycle with nonzero outputs -> all outputs 0 before next edge, stall_o=0.
//  2 Pass-through: start_i=1, PC_i=0x40, instr=ADD x3,x1,x2 (0x002081B3), RegWrite_i=1 -> next edge
//    PC_o=0x40, rd_o=3, rs1_o=1, rs2_o=2, RegWrite_o=1, stall_o=0.
//  3 Load-use: LW x5,0(x1) then ADD x6,x5,x2 -> stall_o=1 one cycle, next EX entry all-zero bubble,
//    then ADD latched; bubble_cnt_o=1 when ID_EX_BUBBLE_CNT_EN.
//  4 LW x0 then instr reading x0 -> stall_o=0, no bubble.
//  5 flush_i=1 with hazard present -> bubble inserted, stall_o=0, bubble_cnt_o unchanged.
//  6 start_i=0 for 3 cycles with pending inputs changing -> all outputs frozen, start_o unchanged.

Source files
------------

// File: rtl/id_ex_hazard_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_reg_if
// Bundles the signals between the ID stage, the ID/EX pipeline register and
// the EX stage.
//
// Ports:
//   ID side  : start_i, flush_i, PC_i, instruction_i, RS1data_i, RS2data_i,
//              imm_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
//              ALUSrc_i, Branch_i, ALUOp_i
//   EX side  : start_o, PC_o, RS1data_o, RS2data_o, imm_o, rs1_o, rs2_o,
//              rd_o, funct_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
//              ALUSrc_o, Branch_o, ALUOp_o
//   Upstream : stall_o (holds the PC and the IF/ID register)
//
// Modports:
//   master : the surrounding pipeline, which drives the *_i signals
//   slave  : the ID/EX register itself
// ---------------------------------------------------------------------------
interface id_ex_hazard_reg_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  start_i;
   logic                  flush_i;
   logic [XLEN-1:0]       PC_i;
   logic [XLEN-1:0]       instruction_i;
   logic [XLEN-1:0]       RS1data_i;
   logic [XLEN-1:0]       RS2data_i;
   logic [XLEN-1:0]       imm_i;
   logic                  RegWrite_i;
   logic                  MemtoReg_i;
   logic                  MemRead_i;
   logic                  MemWrite_i;
   logic                  ALUSrc_i;
   logic                  Branch_i;
   logic [1:0]            ALUOp_i;

   logic                  start_o;
   logic [XLEN-1:0]       PC_o;
   logic [XLEN-1:0]       RS1data_o;
   logic [XLEN-1:0]       RS2data_o;
   logic [XLEN-1:0]       imm_o;
   logic [REG_ADDR_W-1:0] rs1_o;
   logic [REG_ADDR_W-1:0] rs2_o;
   logic [REG_ADDR_W-1:0] rd_o;
   logic [9:0]            funct_o;
   logic                  RegWrite_o;
   logic                  MemtoReg_o;
   logic                  MemRead_o;
   logic                  MemWrite_o;
   logic                  ALUSrc_o;
   logic                  Branch_o;
   logic [1:0]            ALUOp_o;
   logic                  stall_o;

   modport master (
      output start_i, flush_i, PC_i, instruction_i, RS1data_i, RS2data_i, imm_i,
             RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
             ALUOp_i,
      input  start_o, PC_o, RS1data_o, RS2data_o, imm_o, rs1_o, rs2_o, rd_o,
             funct_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o,
             Branch_o, ALUOp_o, stall_o
   );

   modport slave (
      input  start_i, flush_i, PC_i, instruction_i, RS1data_i, RS2data_i, imm_i,
             RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, Branch_i,
             ALUOp_i,
      output start_o, PC_o, RS1data_o, RS2data_o, imm_o, rs1_o, rs2_o, rd_o,
             funct_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o,
             Branch_o, ALUOp_o, stall_o
   );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_reg
// ID/EX pipeline register with built-in load-use hazard detection. It sits
// directly downstream of IF/ID, latches decoded operands and control for EX,
// and requests an upstream stall when the instruction in ID reads the
// destination of a load currently in EX. A load-use hazard or a flush puts
// exactly one all-zero bubble into EX.
//
// Ports:
//   clk          : clock, rising edge
//   rst_i        : asynchronous active-high reset, clears every output
//   bus          : id_ex_hazard_reg_if.slave (ID inputs, EX outputs, stall_o)
//   bubble_cnt_o : [31:0] count of hazard bubbles (only with the option)
//
// Optional feature (macro ID_EX_BUBBLE_CNT_EN):
//   When defined, bubble_cnt_o is added. It counts clock edges on which
//   start_i=1 and a bubble is inserted because of a hazard (a flush-forced
//   bubble is not counted). It wraps from 0xFFFFFFFF to 0.
// ---------------------------------------------------------------------------
module id_ex_hazard_reg #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst_i,
   id_ex_hazard_reg_if.slave  bus
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [31:0]        bubble_cnt_o
`endif
);

   // Everything EX sees, held as one record so that a bubble is simply '0.
   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic [9:0]            funct;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  mem_read;
      logic                  mem_write;
      logic                  alu_src;
      logic                  branch;
      logic [1:0]            alu_op;
   } ex_t;

   ex_t  ex_q;
   ex_t  ex_d;
   logic start_q;
   logic start_d;
   logic hazard;

   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic [REG_ADDR_W-1:0] id_rd;

   // Opcode bits are not needed here; the rs fields are compared for every
   // opcode, which may stall needlessly on instructions without rs2 but is
   // never wrong.
   logic unused_opcode;
   assign unused_opcode = ^bus.instruction_i[6:0];

   assign id_rs1 = bus.instruction_i[15 +: REG_ADDR_W];
   assign id_rs2 = bus.instruction_i[20 +: REG_ADDR_W];
   assign id_rd  = bus.instruction_i[7  +: REG_ADDR_W];

   // Load-use detection against the load now sitting in EX. x0 is never a
   // real dependency. Once a bubble is in EX, mem_read is 0, so the stall
   // releases on its own after exactly one cycle.
   assign hazard = bus.start_i & ex_q.mem_read & (ex_q.rd != '0) &
                   ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

   // A flush kills the instruction in ID, so holding it back is pointless.
   assign bus.stall_o = hazard & ~bus.flush_i;

   // Next-state for the pipeline register: hold when not started,
   // otherwise flush beats hazard beats a normal load from ID.
   always_comb begin
      ex_d    = ex_q;
      start_d = start_q;
      if (bus.start_i) begin
         start_d = 1'b1;
         if (bus.flush_i || hazard) begin
            ex_d = '0;
         end else begin
            ex_d.pc         = bus.PC_i;
            ex_d.rs1_data   = bus.RS1data_i;
            ex_d.rs2_data   = bus.RS2data_i;
            ex_d.imm        = bus.imm_i;
            ex_d.rs1        = id_rs1;
            ex_d.rs2        = id_rs2;
            ex_d.rd         = id_rd;
            ex_d.funct      = {bus.instruction_i[31:25], bus.instruction_i[14:12]};
            ex_d.reg_write  = bus.RegWrite_i;
            ex_d.mem_to_reg = bus.MemtoReg_i;
            ex_d.mem_read   = bus.MemRead_i;
            ex_d.mem_write  = bus.MemWrite_i;
            ex_d.alu_src    = bus.ALUSrc_i;
            ex_d.branch     = bus.Branch_i;
            ex_d.alu_op     = bus.ALUOp_i;
         end
      end
   end

   // Pipeline register flops; reset clears EX immediately, which also
   // drops stall_o in the same instant.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         ex_q    <= '0;
         start_q <= 1'b0;
      end else begin
         ex_q    <= ex_d;
         start_q <= start_d;
      end
   end

   assign bus.start_o    = start_q;
   assign bus.PC_o       = ex_q.pc;
   assign bus.RS1data_o  = ex_q.rs1_data;
   assign bus.RS2data_o  = ex_q.rs2_data;
   assign bus.imm_o      = ex_q.imm;
   assign bus.rs1_o      = ex_q.rs1;
   assign bus.rs2_o      = ex_q.rs2;
   assign bus.rd_o       = ex_q.rd;
   assign bus.funct_o    = ex_q.funct;
   assign bus.RegWrite_o = ex_q.reg_write;
   assign bus.MemtoReg_o = ex_q.mem_to_reg;
   assign bus.MemRead_o  = ex_q.mem_read;
   assign bus.MemWrite_o = ex_q.mem_write;
   assign bus.ALUSrc_o   = ex_q.alu_src;
   assign bus.Branch_o   = ex_q.branch;
   assign bus.ALUOp_o    = ex_q.alu_op;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;
   logic [31:0] bubble_cnt_d;

   // Only hazard bubbles count; a simultaneous flush takes priority and the
   // bubble is then attributed to the flush. Wraps naturally.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bus.start_i && hazard && !bus.flush_i) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
